// File: rtl/fir_pkg.sv
// Shared types and sizing for the FIR frame sequencer.
package fir_pkg;

    localparam int DATA_W   = 12;
    localparam int OUT_W    = 30;
    localparam int TAPS     = 61;
    localparam int PIPE_LAT = 9;

    // Wide enough to count the TAPS-cycle prime (0..TAPS-1).
    localparam int CNT_W = $clog2(TAPS);

    typedef enum logic [1:0] {
        PRIME,
        IDLE,
        RUN,
        FLUSH
    } state_t;

    // Per-sample sideband that travels alongside the filter's data path.
    typedef struct packed {
        logic v;
        logic last;
    } tag_t;

endpackage

// File: rtl/fir_tag_pipe.sv
// Shift register of sample tags, matching the filter's data-path latency.
module fir_tag_pipe
    import fir_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT + 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);

    tag_t [DEPTH-1:0] stage;

    // Advance every tag one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage <= {stage[DEPTH-2:0], tag_in};
        end
    end

    // Any stage holding a valid tag means outputs are still owed.
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage[i].v;
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/fir_frame_ctrl.sv
// Frame sequencer for a free-running, unreset FIR: primes and flushes its
// delay line with zeros and frames the full-convolution output stream.
//
// state | meaning
// PRIME | after reset: drive TAPS zeros to clear the delay line, no tags
// IDLE  | waiting for the first sample of a frame
// RUN   | mid-frame; a missing sample is replaced by a zero (underrun)
// FLUSH | inject TAPS-1 tagged zeros to emit the convolution tail
module fir_frame_ctrl
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic [DATA_W-1:0] fir_filter_in,
    input  logic [OUT_W-1:0]  fir_filter_out,
    output logic              m_valid,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_last,
    output logic              frame_done,
    output logic              underrun,
    output logic              busy
);

    localparam logic [CNT_W-1:0] PRIME_END = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(TAPS - 2);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;
    logic             set_underrun;
    tag_t             push_tag;
    tag_t             in_tag;
    tag_t             out_tag;
    logic             pipe_busy;

    // Next-state, handshake and tag generation.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        s_ready      = 1'b0;
        push_tag     = '0;
        set_underrun = 1'b0;
        case (state)
            PRIME: begin
                if (cnt == PRIME_END) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    push_tag.v = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = s_last ? FLUSH : RUN;
                end
            end
            RUN: begin
                s_ready    = 1'b1;
                // Either the accepted sample or a substituted zero enters the filter.
                push_tag.v = 1'b1;
                if (s_valid) begin
                    if (s_last) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = '0;
                    end
                end else begin
                    set_underrun = 1'b1;
                end
            end
            FLUSH: begin
                push_tag.v = 1'b1;
                if (cnt == FLUSH_END) begin
                    push_tag.last = 1'b1;
                    state_nxt     = IDLE;
                    cnt_nxt       = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = PRIME;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign accept = s_valid && s_ready;

    // State register and prime/flush counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PRIME;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Filter input: the accepted sample, otherwise zero; its tag rides alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fir_filter_in <= '0;
            in_tag        <= '0;
        end else begin
            fir_filter_in <= accept ? s_data : '0;
            in_tag        <= push_tag;
        end
    end

    fir_tag_pipe #(
        .DEPTH (PIPE_LAT + 1)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (in_tag),
        .tag_out   (out_tag),
        .any_valid (pipe_busy)
    );

    // Output framing registered from the delayed tag and the filter result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            m_valid    <= out_tag.v;
            m_data     <= fir_filter_out;
            m_last     <= out_tag.v & out_tag.last;
            frame_done <= out_tag.v & out_tag.last;
        end
    end

    // Underrun stays set until reset so software can see any mid-frame gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (set_underrun) begin
            underrun <= 1'b1;
        end
    end

    assign busy = (state != IDLE) || in_tag.v || pipe_busy || m_valid;

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Self-checking bench for fir_frame_ctrl with a cycle model of the external
// filter and a convolution reference for the expected output stream.
module tb_fir_frame_ctrl;
    import fir_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic [DATA_W-1:0] fir_filter_in;
    logic [OUT_W-1:0]  fir_filter_out;
    logic              m_valid;
    logic [OUT_W-1:0]  m_data;
    logic              m_last;
    logic              frame_done;
    logic              underrun;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    fir_frame_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .fir_filter_in  (fir_filter_in),
        .fir_filter_out (fir_filter_out),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_last         (m_last),
        .frame_done     (frame_done),
        .underrun       (underrun),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- external filter model (no reset) ----------------
    int                       h [TAPS];
    logic signed [DATA_W-1:0] dl [TAPS];
    longint                   fo_pipe [PIPE_LAT];
    longint                   fo_acc;

    initial begin
        for (int k = 0; k <= TAPS / 2; k++) begin
            h[k] = ((k * k * 37 + k * 11) % 4001) - 2000;
        end
        h[0] = 434;
        h[1] = 270;
        h[TAPS / 2] = 32768;
        for (int k = 0; k < TAPS / 2; k++) h[TAPS - 1 - k] = h[k];
        for (int k = 0; k < TAPS; k++) dl[k] = DATA_W'($urandom);
        for (int k = 0; k < PIPE_LAT; k++) fo_pipe[k] = longint'($urandom);
        fir_filter_out = OUT_W'($urandom);
    end

    always @(posedge clk) begin
        for (int k = TAPS - 1; k > 0; k--) dl[k] = dl[k-1];
        dl[0] = fir_filter_in;
        fo_acc = 0;
        for (int k = 0; k < TAPS; k++) fo_acc += longint'(h[k]) * longint'(dl[k]);
        fir_filter_out <= OUT_W'(fo_pipe[PIPE_LAT-1]);
        for (int k = PIPE_LAT - 1; k > 0; k--) fo_pipe[k] = fo_pipe[k-1];
        fo_pipe[0] = fo_acc;
    end

    // ---------------- output monitor ----------------
    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
        logic             fd;
        int               t;
    } obs_t;
    obs_t obs_q[$];

    always @(negedge clk) begin
        if (m_valid === 1'b1) obs_q.push_back('{m_data, m_last, frame_done, cyc});
    end

    // ---------------- reference: full linear convolution per frame ----------------
    logic [OUT_W-1:0] exp_d[$];
    logic             exp_l[$];

    function automatic void model_frame(input int s[$]);
        int n;
        longint acc;
        n = s.size();
        for (int j = 0; j < n + TAPS - 1; j++) begin
            acc = 0;
            for (int i = 0; i < n; i++) begin
                if (j - i >= 0 && j - i < TAPS) acc += longint'(h[j-i]) * longint'(s[i]);
            end
            exp_d.push_back(OUT_W'(acc));
            exp_l.push_back(j == n + TAPS - 2);
        end
    endfunction

    function automatic void clear_streams();
        obs_q.delete();
        exp_d.delete();
        exp_l.delete();
    endfunction

    // Drive one frame; a gap of gap_len idle cycles is placed before sample gap_at.
    task automatic send_frame(input int s[$], input int gap_at, input int gap_len,
                              output int first_acc, output int last_acc);
        int eff[$];
        int n;
        int w;
        n = s.size();
        first_acc = -1;
        last_acc = -1;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && i == gap_at && gap_len > 0) begin
                s_valid = 1'b0;
                s_last = 1'b0;
                repeat (gap_len) @(negedge clk);
                for (int g = 0; g < gap_len; g++) eff.push_back(0);
            end
            s_valid = 1'b1;
            s_data = DATA_W'(s[i]);
            s_last = (i == n - 1);
            w = 0;
            while (s_ready !== 1'b1 && w < 500) begin
                @(negedge clk);
                w++;
            end
            if (w >= 500) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: got s_ready=%b after %0d cycles, want 1", s_ready, w);
            end
            @(negedge clk);
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            eff.push_back(s[i]);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        model_frame(eff);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (obs_q.size() < exp_d.size() && w < 2000) begin
            @(negedge clk);
            w++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic measure_prime(output int n, output int seen_valid);
        n = 0;
        seen_valid = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            if (m_valid !== 1'b0) seen_valid++;
            n++;
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        int sv;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({m_valid, m_last, frame_done, underrun, s_ready} !== 5'b0 || fir_filter_in !== '0 || m_data !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got mv=%b ml=%b fd=%b ur=%b rdy=%b fin=%0d md=%0d, want all 0",
                     m_valid, m_last, frame_done, underrun, s_ready, fir_filter_in, m_data);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy: got %b, want 1", busy);
        end
        rst = 1'b0;
        measure_prime(n, sv);
        vectors++;
        if (n != TAPS) begin
            miscompares++;
            $display("FAIL prime_length: got %0d cycles, want %0d", n, TAPS);
        end
        vectors++;
        if (sv != 0) begin
            miscompares++;
            $display("FAIL prime_no_valid: got %0d m_valid cycles, want 0", sv);
        end
    endtask

    task automatic test_impulse();
        int q[$];
        int fa;
        int la;
        clear_streams();
        q = {1};
        send_frame(q, 0, 0, fa, la);
        wait_drain();
        vectors++;
        if (obs_q.size() != TAPS) begin
            miscompares++;
            $display("FAIL impulse_count: got %0d outputs, want %0d", obs_q.size(), TAPS);
        end
        if (obs_q.size() >= TAPS) begin
            vectors++;
            if (obs_q[0].t - fa != PIPE_LAT + 2) begin
                miscompares++;
                $display("FAIL impulse_latency: got %0d cycles, want %0d", obs_q[0].t - fa, PIPE_LAT + 2);
            end
            vectors++;
            if ($signed(obs_q[0].data) != 434 || $signed(obs_q[1].data) != 270 ||
                $signed(obs_q[30].data) != 32768 || $signed(obs_q[60].data) != 434) begin
                miscompares++;
                $display("FAIL impulse_coeffs: got %0d %0d %0d %0d, want 434 270 32768 434",
                         $signed(obs_q[0].data), $signed(obs_q[1].data), $signed(obs_q[30].data), $signed(obs_q[60].data));
            end
            vectors++;
            if (obs_q[60].last !== 1'b1 || obs_q[60].fd !== 1'b1) begin
                miscompares++;
                $display("FAIL impulse_last: got last=%b done=%b, want 1 1", obs_q[60].last, obs_q[60].fd);
            end
        end
        for (int i = 0; i < exp_d.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i].data !== exp_d[i] || obs_q[i].last !== exp_l[i] || obs_q[i].fd !== exp_l[i]) begin
                miscompares++;
                $display("FAIL impulse_out[%0d]: got data=%0d last=%b done=%b, want data=%0d last=%b",
                         i, $signed(obs_q[i].data), obs_q[i].last, obs_q[i].fd, $signed(exp_d[i]), exp_l[i]);
            end
        end
    endtask

    task automatic test_frame4();
        int q[$];
        int fa;
        int la;
        int n;
        clear_streams();
        q = {1, 0, 0, -1};
        send_frame(q, 0, 0, fa, la);
        n = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != TAPS - 1) begin
            miscompares++;
            $display("FAIL frame4_flush_len: got %0d ready-low cycles, want %0d", n, TAPS - 1);
        end
        wait_drain();
        vectors++;
        if (obs_q.size() != 4 + TAPS - 1) begin
            miscompares++;
            $display("FAIL frame4_count: got %0d outputs, want %0d", obs_q.size(), 4 + TAPS - 1);
        end
        for (int i = 0; i < exp_d.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i].data !== exp_d[i] || obs_q[i].last !== exp_l[i] || obs_q[i].fd !== exp_l[i]) begin
                miscompares++;
                $display("FAIL frame4_out[%0d]: got data=%0d last=%b done=%b, want data=%0d last=%b",
                         i, $signed(obs_q[i].data), obs_q[i].last, obs_q[i].fd, $signed(exp_d[i]), exp_l[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a[$];
        int b[$];
        int fa1, la1, fa2, la2;
        clear_streams();
        for (int i = 0; i < 3; i++) a.push_back(int'($urandom_range(0, 4095)) - 2048);
        for (int i = 0; i < 4; i++) b.push_back(int'($urandom_range(0, 4095)) - 2048);
        send_frame(a, 0, 0, fa1, la1);
        send_frame(b, 0, 0, fa2, la2);
        vectors++;
        if (fa2 - la1 != TAPS) begin
            miscompares++;
            $display("FAIL b2b_accept_gap: got %0d cycles, want %0d", fa2 - la1, TAPS);
        end
        wait_drain();
        vectors++;
        if (obs_q.size() != exp_d.size()) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d outputs, want %0d", obs_q.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i].data !== exp_d[i] || obs_q[i].last !== exp_l[i] || obs_q[i].fd !== exp_l[i] ||
                obs_q[i].t != obs_q[0].t + i) begin
                miscompares++;
                $display("FAIL b2b_out[%0d]: got data=%0d last=%b done=%b t=%0d, want data=%0d last=%b t=%0d",
                         i, $signed(obs_q[i].data), obs_q[i].last, obs_q[i].fd, obs_q[i].t,
                         $signed(exp_d[i]), exp_l[i], obs_q[0].t + i);
            end
        end
    endtask

    task automatic test_underrun();
        int q[$];
        int fa;
        int la;
        clear_streams();
        vectors++;
        if (underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL underrun_pre: got %b, want 0", underrun);
        end
        for (int i = 0; i < 5; i++) q.push_back(int'($urandom_range(0, 4095)) - 2048);
        send_frame(q, 2, 2, fa, la);
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_set: got %b, want 1", underrun);
        end
        wait_drain();
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_sticky: got %b, want 1", underrun);
        end
        vectors++;
        if (obs_q.size() != 5 + 2 + TAPS - 1) begin
            miscompares++;
            $display("FAIL underrun_count: got %0d outputs, want %0d", obs_q.size(), 5 + 2 + TAPS - 1);
        end
        for (int i = 0; i < exp_d.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i].data !== exp_d[i] || obs_q[i].last !== exp_l[i] || obs_q[i].fd !== exp_l[i]) begin
                miscompares++;
                $display("FAIL underrun_out[%0d]: got data=%0d last=%b done=%b, want data=%0d last=%b",
                         i, $signed(obs_q[i].data), obs_q[i].last, obs_q[i].fd, $signed(exp_d[i]), exp_l[i]);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        int q[$];
        int fa;
        int la;
        int n;
        int sv;
        clear_streams();
        q = {700, -300, 55};
        send_frame(q, 0, 0, fa, la);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({m_valid, m_last, frame_done, underrun, s_ready} !== 5'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got mv=%b ml=%b fd=%b ur=%b rdy=%b, want all 0",
                     m_valid, m_last, frame_done, underrun, s_ready);
        end
        repeat (3) @(negedge clk);
        clear_streams();
        rst = 1'b0;
        measure_prime(n, sv);
        vectors++;
        if (n != TAPS || sv != 0) begin
            miscompares++;
            $display("FAIL midrst_prime: got %0d cycles with %0d valids, want %0d with 0", n, sv, TAPS);
        end
        repeat (40) @(negedge clk);
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL midrst_no_stale: got %0d outputs, want 0", obs_q.size());
        end
        q = {1};
        send_frame(q, 0, 0, fa, la);
        wait_drain();
        vectors++;
        if (obs_q.size() != TAPS) begin
            miscompares++;
            $display("FAIL midrst_impulse_count: got %0d outputs, want %0d", obs_q.size(), TAPS);
        end
        for (int i = 0; i < TAPS && i < obs_q.size(); i++) begin
            vectors++;
            if ($signed(obs_q[i].data) != h[i] || obs_q[i].last !== (i == TAPS - 1)) begin
                miscompares++;
                $display("FAIL midrst_impulse[%0d]: got data=%0d last=%b, want data=%0d last=%b",
                         i, $signed(obs_q[i].data), obs_q[i].last, h[i], (i == TAPS - 1));
            end
        end
    endtask

    task automatic test_random_frames();
        int q[$];
        int fa;
        int la;
        int n;
        int gat;
        int glen;
        clear_streams();
        for (int f = 0; f < 6; f++) begin
            q.delete();
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(0, 4095)) - 2048);
            gat = (n >= 2) ? int'($urandom_range(1, n - 1)) : 0;
            glen = (n >= 2) ? int'($urandom_range(0, 2)) : 0;
            send_frame(q, gat, glen, fa, la);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain();
        vectors++;
        if (obs_q.size() != exp_d.size()) begin
            miscompares++;
            $display("FAIL random_count: got %0d outputs, want %0d", obs_q.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i].data !== exp_d[i] || obs_q[i].last !== exp_l[i] || obs_q[i].fd !== exp_l[i]) begin
                miscompares++;
                $display("FAIL random_out[%0d]: got data=%0d last=%b done=%b, want data=%0d last=%b",
                         i, $signed(obs_q[i].data), obs_q[i].last, obs_q[i].fd, $signed(exp_d[i]), exp_l[i]);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_busy: got %b, want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_frame4();
        test_back_to_back();
        test_underrun();
        test_reset_mid_flush();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
